// File: rtl/cmd_pkg.sv
// -----------------------------------------------------------------------------
// cmd_pkg
// Shared definitions for the command executor: command opcodes, response
// status codes, the executor state enum and response sizing helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package cmd_pkg;

  // Command opcodes as delivered by command_decoder
  localparam logic [7:0] CMD_WRITE   = 8'h00;
  localparam logic [7:0] CMD_READ    = 8'h01;
  localparam logic [7:0] CMD_CLRSTAT = 8'h02;

  // Response status codes
  localparam logic [7:0] ST_OK       = 8'h00;
  localparam logic [7:0] ST_BAD_ADDR = 8'hE1;
  localparam logic [7:0] ST_BAD_CMD  = 8'hE2;

  // Executor state machine
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXEC    = 2'd1,
    S_TX_LOAD = 2'd2,
    S_TX_WAIT = 2'd3
  } state_t;

  // Index width for a bank of n registers (never zero, so a 1-entry bank
  // still has a legal select port)
  function automatic int regbank_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // True for the commands that address the register bank
  function automatic logic is_reg_cmd(input logic [7:0] cmd);
    return (cmd == CMD_WRITE) || (cmd == CMD_READ);
  endfunction

endpackage

// File: rtl/cmd_regbank.sv
// -----------------------------------------------------------------------------
// cmd_regbank
// NUM_REGS x 32-bit register array with asynchronous clear, one synchronous
// write port and one combinational read port.
//
// Ports:
//   clock    in   system clock (rising edge)
//   reset_n  in   asynchronous active-low clear of every register
//   wr_en    in   write enable
//   wr_idx   in   [AW-1:0] write index
//   wr_data  in   [31:0]   write data
//   rd_idx   in   [AW-1:0] read index
//   rd_data  out  [31:0]   combinational read data
// -----------------------------------------------------------------------------
module cmd_regbank
  import cmd_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             wr_en,
  input  logic [regbank_aw(NUM_REGS)-1:0]  wr_idx,
  input  logic [31:0]                      wr_data,
  input  logic [regbank_aw(NUM_REGS)-1:0]  rd_idx,
  output logic [31:0]                      rd_data
);

  localparam int AW = regbank_aw(NUM_REGS);

  logic [31:0] regs [NUM_REGS];

  // One register per generate instance; the async clear has to reach every
  // entry, so this is built from flops rather than an inferred RAM.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [31:0] q;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        q <= '0;
      end else if (wr_en && (wr_idx == AW'(gi))) begin
        q <= wr_data;
      end
    end

    assign regs[gi] = q;
  end

  assign rd_data = regs[rd_idx];

endmodule

// File: rtl/cmd_executor.sv
// -----------------------------------------------------------------------------
// cmd_executor
// Executes frames from command_decoder against a local 32-bit register bank
// and streams a byte-wise response toward uart_tx.
//
// Parameters:
//   NUM_REGS      number of 32-bit registers (power of two, <= 256)
// Build option:
//   CMD_EXEC_ECHO_EN  when defined, each response is prefixed with the
//                     latched command byte (2 or 6 bytes instead of 1 or 5)
//
// Ports:
//   clock        in   system clock (rising edge)
//   reset_n      in   asynchronous active-low reset
//   i_command    in   [7:0]  command byte
//   i_address    in   [7:0]  register address
//   i_data       in   [31:0] write data
//   i_done       in   frame-complete flag, rising edge starts a frame
//   o_tx_byte    out  [7:0]  response byte
//   o_tx_valid   out  one-cycle pulse starting transmission of o_tx_byte
//   i_tx_done    in   one-cycle pulse when uart_tx finished the byte
//   o_wr_strobe  out  one-cycle pulse per successful register write
//   o_wr_addr    out  [7:0]  address of that write
//   o_wr_data    out  [31:0] data of that write
//   o_busy       out  high whenever not idle
//   o_overrun    out  sticky: a frame arrived while busy and was dropped
// -----------------------------------------------------------------------------
module cmd_executor
  import cmd_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  i_command,
  input  logic [7:0]  i_address,
  input  logic [31:0] i_data,
  input  logic        i_done,
  output logic [7:0]  o_tx_byte,
  output logic        o_tx_valid,
  input  logic        i_tx_done,
  output logic        o_wr_strobe,
  output logic [7:0]  o_wr_addr,
  output logic [31:0] o_wr_data,
  output logic        o_busy,
  output logic        o_overrun
);

  localparam int         AW         = regbank_aw(NUM_REGS);
  // Nine bits so that NUM_REGS = 256 still compares correctly
  localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t      state;
  state_t      state_next;

  logic        done_q;      // previous i_done, for rising-edge detection
  logic        tx_done_q;   // i_tx_done seen during TX_WAIT, acted on next cycle
  logic [7:0]  cmd_q;
  logic [7:0]  addr_q;
  logic [31:0] data_q;
  logic [2:0]  count;       // response bytes still to be acknowledged
  logic [39:0] resp;        // bytes queued behind o_tx_byte, next one in [39:32]

  // ---------------------------------------------------------------------------
  // Decode of the latched frame (only consumed while in EXEC)
  // ---------------------------------------------------------------------------
  logic        frame_rise;
  logic        is_write;
  logic        is_read;
  logic        is_clr;
  logic        addr_ok;
  logic        write_ok;
  logic        read_ok;
  logic [7:0]  status;
  logic [31:0] rd_data;
  logic [31:0] read_word;
  logic [47:0] resp_full;
  logic [2:0]  resp_len;
  logic        reg_we;

  assign frame_rise = i_done && !done_q;

  assign is_write = (cmd_q == CMD_WRITE);
  assign is_read  = (cmd_q == CMD_READ);
  assign is_clr   = (cmd_q == CMD_CLRSTAT);
  assign addr_ok  = ({1'b0, addr_q} < NUM_REGS_W);
  assign write_ok = is_write && addr_ok;
  assign read_ok  = is_read && addr_ok;

  always_comb begin
    status = ST_OK;
    if (!(is_reg_cmd(cmd_q) || is_clr)) begin
      status = ST_BAD_CMD;
    end else if (is_reg_cmd(cmd_q) && !addr_ok) begin
      status = ST_BAD_ADDR;
    end
  end

  // Read data is sampled into the response shifter in EXEC, so a later
  // write can never alter bytes already queued for transmission.
  assign read_word = read_ok ? rd_data : 32'h0;

  // Response is packed MSB-first into 48 bits; unused tail bytes are zero.
`ifdef CMD_EXEC_ECHO_EN
  assign resp_full = {cmd_q, status, read_word};
  assign resp_len  = read_ok ? 3'd6 : 3'd2;
`else
  assign resp_full = {status, read_word, 8'h00};
  assign resp_len  = read_ok ? 3'd5 : 3'd1;
`endif

  // ---------------------------------------------------------------------------
  // Register bank
  // ---------------------------------------------------------------------------
  cmd_regbank #(
    .NUM_REGS (NUM_REGS)
  ) u_regbank (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (reg_we),
    .wr_idx  (addr_q[AW-1:0]),
    .wr_data (data_q),
    .rd_idx  (addr_q[AW-1:0]),
    .rd_data (rd_data)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    o_tx_valid = 1'b0;
    o_busy     = (state != S_IDLE);
    reg_we     = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_rise) begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        reg_we     = write_ok;
        state_next = S_TX_LOAD;
      end
      S_TX_LOAD: begin
        o_tx_valid = 1'b1;
        state_next = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (tx_done_q) begin
          state_next = (count == 3'd1) ? S_IDLE : S_TX_LOAD;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done_q      <= 1'b0;
      tx_done_q   <= 1'b0;
      cmd_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      count       <= '0;
      resp        <= '0;
      o_tx_byte   <= '0;
      o_wr_strobe <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
      o_overrun   <= 1'b0;
    end else begin
      done_q      <= i_done;
      // Acknowledges arriving outside TX_WAIT are discarded here; the one
      // cycle of delay puts the next o_tx_valid two cycles after i_tx_done.
      tx_done_q   <= i_tx_done && (state == S_TX_WAIT);
      o_wr_strobe <= 1'b0;

      if ((state == S_IDLE) && frame_rise) begin
        cmd_q  <= i_command;
        addr_q <= i_address;
        data_q <= i_data;
      end

      // A drop and a CLRSTAT in the same cycle: the set has priority.
      if (frame_rise && (state != S_IDLE)) begin
        o_overrun <= 1'b1;
      end else if ((state == S_EXEC) && is_clr) begin
        o_overrun <= 1'b0;
      end

      if (state == S_EXEC) begin
        o_tx_byte <= resp_full[47:40];
        resp      <= resp_full[39:0];
        count     <= resp_len;
        if (write_ok) begin
          o_wr_strobe <= 1'b1;
          o_wr_addr   <= addr_q;
          o_wr_data   <= data_q;
        end
      end

      if ((state == S_TX_WAIT) && tx_done_q) begin
        count <= count - 3'd1;
        if (count != 3'd1) begin
          o_tx_byte <= resp[39:32];
          resp      <= {resp[31:0], 8'h00};
        end
      end
    end
  end

endmodule

// File: tb/tb_cmd_executor.sv
// -----------------------------------------------------------------------------
// tb_cmd_executor
// Randomised frames against a queue-based reference model of the command
// executor. A driver process plays command_decoder and uart_tx with exact
// cycle timing; a compare process checks every o_tx_valid byte and every
// o_wr_strobe against queues filled from the model.
// -----------------------------------------------------------------------------
module tb_cmd_executor;

  localparam int NUM_REGS = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  i_command = '0;
  logic [7:0]  i_address = '0;
  logic [31:0] i_data = '0;
  logic        i_done = 1'b0;
  logic [7:0]  o_tx_byte;
  logic        o_tx_valid;
  logic        i_tx_done = 1'b0;
  logic        o_wr_strobe;
  logic [7:0]  o_wr_addr;
  logic [31:0] o_wr_data;
  logic        o_busy;
  logic        o_overrun;

  always #5 clock = ~clock;

  cmd_executor #(
    .NUM_REGS (NUM_REGS)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_command   (i_command),
    .i_address   (i_address),
    .i_data      (i_data),
    .i_done      (i_done),
    .o_tx_byte   (o_tx_byte),
    .o_tx_valid  (o_tx_valid),
    .i_tx_done   (i_tx_done),
    .o_wr_strobe (o_wr_strobe),
    .o_wr_addr   (o_wr_addr),
    .o_wr_data   (o_wr_data),
    .o_busy      (o_busy),
    .o_overrun   (o_overrun)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef logic [7:0] bq_t[$];

  logic [31:0] model_regs [NUM_REGS];
  logic        model_ovr = 1'b0;
  logic [7:0]  exp_tx[$];
  logic [39:0] exp_wr[$];   // {addr, data}

  // Response bytes a frame must produce, given the current model state
  function automatic bq_t model_resp(input logic [7:0] c, input logic [7:0] a);
    bq_t         q;
    logic [7:0]  st;
    logic [31:0] w;
    if (c > 8'h02)                          st = 8'hE2;
    else if (c != 8'h02 && a >= NUM_REGS)   st = 8'hE1;
    else                                    st = 8'h00;
`ifdef CMD_EXEC_ECHO_EN
    q.push_back(c);
`endif
    q.push_back(st);
    if (c == 8'h01 && st == 8'h00) begin
      w = model_regs[a[3:0]];
      q.push_back(w[31:24]);
      q.push_back(w[23:16]);
      q.push_back(w[15:8]);
      q.push_back(w[7:0]);
    end
    return q;
  endfunction

  task automatic pin_resp(input string name, input bq_t got, input bq_t want);
    check({name, "_len"}, 64'(got.size()), 64'(want.size()));
    for (int i = 0; i < want.size() && i < got.size(); i++) begin
      check(name, 64'(got[i]), 64'(want[i]));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Compare process: every transmitted byte and every write strobe
  // ---------------------------------------------------------------------------
  always @(negedge clock) begin
    if (reset_n) begin
      if (o_tx_valid) begin
        if (exp_tx.size() == 0) check("tx_spurious_valid", 64'(o_tx_valid), 64'd0);
        else                    check("tx_byte", 64'(o_tx_byte), 64'(exp_tx.pop_front()));
      end
      if (o_wr_strobe) begin
        if (exp_wr.size() == 0) check("wr_spurious_strobe", 64'(o_wr_strobe), 64'd0);
        else                    check("wr_addr_data", 64'({o_wr_addr, o_wr_data}), 64'(exp_wr.pop_front()));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame driver: plays command_decoder and uart_tx.
  // inject: raise a second i_done during the first TX_WAIT (dropped frame).
  // reset_at: assert reset when byte number reset_at is launched (-1: never).
  // ---------------------------------------------------------------------------
  task automatic run_frame(input logic [7:0] c, input logic [7:0] a, input logic [31:0] d,
                           input bit inject, input int reset_at);
    bq_t q;
    bit  wr_ok;
    int  n;
    int  r;
    q     = model_resp(c, a);
    n     = q.size();
    wr_ok = (c == 8'h00) && (a < NUM_REGS);
    foreach (q[i]) exp_tx.push_back(q[i]);
    if (wr_ok) begin
      exp_wr.push_back({a, d});
      model_regs[a[3:0]] = d;
    end
    if (c == 8'h02) model_ovr = 1'b0;
    $display("[TB] frame cmd=%02h addr=%02h data=%08h bytes=%0d drop=%0d", c, a, d, n, inject);

    @(posedge clock); #1;
    i_command = c; i_address = a; i_data = d; i_done = 1'b1;
    @(posedge clock); #1;                       // edge seen -> EXEC
    i_done = 1'b0;
    check("busy_in_exec", 64'(o_busy), 64'd1);
    @(posedge clock);
    @(negedge clock);                           // N+2
    check("first_valid_latency", 64'(o_tx_valid), 64'd1);
    check("wr_strobe_timing", 64'(o_wr_strobe), 64'(wr_ok));

    for (int i = 0; i < n; i++) begin
      if (i == reset_at) begin
        #2;
        reset_n = 1'b0;
        exp_tx.delete();
        exp_wr.delete();
        foreach (model_regs[k]) model_regs[k] = '0;
        model_ovr = 1'b0;
        #1;
        check("rst_tx_valid",  64'(o_tx_valid),  64'd0);
        check("rst_tx_byte",   64'(o_tx_byte),   64'd0);
        check("rst_wr_strobe", 64'(o_wr_strobe), 64'd0);
        check("rst_wr_addr",   64'(o_wr_addr),   64'd0);
        check("rst_wr_data",   64'(o_wr_data),   64'd0);
        check("rst_busy",      64'(o_busy),      64'd0);
        check("rst_overrun",   64'(o_overrun),   64'd0);
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (12) @(posedge clock);           // compare process flags any stray valid
        @(negedge clock);
        check("post_rst_busy", 64'(o_busy), 64'd0);
        return;
      end
      @(posedge clock);                         // now in TX_WAIT
      r = $urandom_range(0, 2);
      repeat (r) @(posedge clock);
      if (inject && i == 0) begin
        #1;
        i_command = 8'h00;
        i_address = a ^ 8'h01;
        i_data    = $urandom;
        i_done    = 1'b1;
        model_ovr = 1'b1;
        @(posedge clock); #1;
        i_done = 1'b0;
        check("drop_keeps_busy", 64'(o_busy), 64'd1);
        @(posedge clock);
      end
      #1 i_tx_done = 1'b1;                      // cycle M
      @(posedge clock); #1;
      i_tx_done = 1'b0;
      check("busy_at_accept", 64'(o_busy), 64'd1);
      @(posedge clock);
      @(negedge clock);                         // M+2
      if (i < n - 1) begin
        check("next_valid_latency", 64'(o_tx_valid), 64'd1);
      end else begin
        check("idle_after_last", 64'(o_busy), 64'd0);
        check("no_valid_after_last", 64'(o_tx_valid), 64'd0);
      end
    end
    check("overrun_flag", 64'(o_overrun), 64'(model_ovr));
    check("tx_queue_drained", 64'(exp_tx.size()), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0]  c;
    logic [7:0]  a;
    logic [31:0] d;
    bq_t         want;
    foreach (model_regs[k]) model_regs[k] = '0;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_tx_valid",  64'(o_tx_valid),  64'd0);
    check("reset_tx_byte",   64'(o_tx_byte),   64'd0);
    check("reset_busy",      64'(o_busy),      64'd0);
    check("reset_overrun",   64'(o_overrun),   64'd0);
    check("reset_wr_strobe", 64'(o_wr_strobe), 64'd0);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clock);

    // WRITE addr 1
`ifdef CMD_EXEC_ECHO_EN
    want = '{8'h00, 8'h00};
`else
    want = '{8'h00};
`endif
    pin_resp("pin_write", model_resp(8'h00, 8'h01), want);
    run_frame(8'h00, 8'h01, 32'hAF32CD85, 1'b0, -1);
    check("wr_addr_held", 64'(o_wr_addr), 64'h01);
    check("wr_data_held", 64'(o_wr_data), 64'hAF32CD85);

    // READ addr 1
`ifdef CMD_EXEC_ECHO_EN
    want = '{8'h01, 8'h00, 8'hAF, 8'h32, 8'hCD, 8'h85};
`else
    want = '{8'h00, 8'hAF, 8'h32, 8'hCD, 8'h85};
`endif
    pin_resp("pin_read", model_resp(8'h01, 8'h01), want);
    run_frame(8'h01, 8'h01, 32'h0, 1'b0, -1);

    // READ addr 0x10: bad address
`ifdef CMD_EXEC_ECHO_EN
    want = '{8'h01, 8'hE1};
`else
    want = '{8'hE1};
`endif
    pin_resp("pin_bad_addr", model_resp(8'h01, 8'h10), want);
    run_frame(8'h01, 8'h10, 32'h0, 1'b0, -1);

    // WRITE addr 0xFF: bad address, no strobe
    run_frame(8'h00, 8'hFF, 32'h12345678, 1'b0, -1);

    // Unknown command 0x07
`ifdef CMD_EXEC_ECHO_EN
    want = '{8'h07, 8'hE2};
`else
    want = '{8'hE2};
`endif
    pin_resp("pin_bad_cmd", model_resp(8'h07, 8'h01), want);
    run_frame(8'h07, 8'h01, 32'hDEADBEEF, 1'b0, -1);

    // Dropped frame sets overrun, CLRSTAT clears it
    run_frame(8'h01, 8'h01, 32'h0, 1'b1, -1);
    check("overrun_set", 64'(o_overrun), 64'd1);
`ifdef CMD_EXEC_ECHO_EN
    want = '{8'h02, 8'h00};
`else
    want = '{8'h00};
`endif
    pin_resp("pin_clrstat", model_resp(8'h02, 8'h00), want);
    run_frame(8'h02, 8'h00, 32'h0, 1'b0, -1);
    check("overrun_cleared", 64'(o_overrun), 64'd0);

    // Random frames
    for (int k = 0; k < 50; k++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 4)       c = 8'h00;
      else if (sel < 8)  c = 8'h01;
      else if (sel == 8) c = 8'h02;
      else               c = 8'($urandom_range(3, 255));
      if ($urandom_range(0, 5) == 0) a = 8'($urandom_range(16, 255));
      else                           a = 8'($urandom_range(0, 15));
      d = $urandom;
      run_frame(c, a, d, ($urandom_range(0, 7) == 0), -1);
    end

    // Reset during the third byte of a READ (with overrun set beforehand)
    run_frame(8'h00, 8'h01, 32'hAF32CD85, 1'b0, -1);
    run_frame(8'h01, 8'h01, 32'h0, 1'b1, 2);

    // Register bank was cleared
`ifdef CMD_EXEC_ECHO_EN
    want = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`else
    want = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
    pin_resp("pin_read_after_reset", model_resp(8'h01, 8'h01), want);
    run_frame(8'h01, 8'h01, 32'h0, 1'b0, -1);

    repeat (4) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
